// File: rtl/mio_pkg.sv
// Shared types and constants for the CPU/DMA memory-port arbiter.
package mio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mio_state_e;

    localparam logic        OWN_CPU  = 1'b0;
    localparam logic        OWN_DMA  = 1'b1;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mio_timeout_cnt.sv
// Saturating watchdog counter; expired is high once TIMEOUT-1 cycles have been counted.
module mio_timeout_cnt #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Holding at LAST instead of wrapping keeps expired stable until cleared.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/mio_bus_arbiter.sv
// Shares one memory/IO slave port between the CPU data interface and a DMA master.
// Handshake: a master holds req and fields until its one-cycle ready/ack pulse.
module mio_bus_arbiter
    import mio_pkg::*;
#(
    parameter int TIMEOUT  = 15,
    parameter int CPU_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        owner,
    output logic        bus_err,
    output mio_state_e  state_dbg
);

    mio_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_owner_q, last_owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dma_rdata_q, dma_rdata_d;
    logic        err_pending_q, err_pending_d;
    logic        grant_dma;
    logic        expired;

    mio_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (state_q == IDLE),
        .en      ((state_q == BUSY) && !mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        we_d          = we_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        dma_rdata_d   = dma_rdata_q;
        err_pending_d = err_pending_q;
        grant_dma     = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_req || dma_req) begin
                    // On a tie round-robin favours whoever did not go last.
                    grant_dma     = dma_req && (!cpu_req ||
                                    ((CPU_PRIO == 0) && (last_owner_q == OWN_CPU)));
                    owner_d       = grant_dma ? OWN_DMA : OWN_CPU;
                    we_d          = grant_dma ? dma_we    : cpu_we;
                    addr_d        = grant_dma ? dma_addr  : cpu_addr;
                    wdata_d       = grant_dma ? dma_wdata : cpu_wdata;
                    err_pending_d = 1'b0;
                    state_d       = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    if (owner_q == OWN_DMA) dma_rdata_d = mem_rdata;
                    else                    cpu_rdata_d = mem_rdata;
                    state_d = DONE;
                end else if (expired) begin
                    if (owner_q == OWN_DMA) dma_rdata_d = ERR_DATA;
                    else                    cpu_rdata_d = ERR_DATA;
                    err_pending_d = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            owner_q       <= OWN_CPU;
            last_owner_q  <= OWN_DMA;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
            err_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            we_q          <= we_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
            err_pending_q <= err_pending_d;
        end
    end

    assign mem_req   = (state_q == BUSY);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign cpu_ready = (state_q == DONE) && (owner_q == OWN_CPU);
    assign dma_ack   = (state_q == DONE) && (owner_q == OWN_DMA);
    assign bus_err   = (state_q == DONE) && err_pending_q;
    assign owner     = owner_q;
    assign state_dbg = state_q;

endmodule
